// File: rtl/rj_loader_if.sv
// Bundle between the rj_loader and its neighbours: serial bit stream in, rj memory write port out.
// Carries sum_err only when RJ_LOADER_SUM_CHK_EN is defined.
interface rj_loader_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              frame;
  logic              in_bit;
  logic              bit_valid;
  logic              rj_wr_en;
  logic [ADDR_W-1:0] rj_wr_addr;
  logic [WORD_W-1:0] rj_wr_data;
  logic              busy;
  logic              done;
`ifdef RJ_LOADER_SUM_CHK_EN
  logic              sum_err;

  modport master (
    output start, frame, in_bit, bit_valid,
    input  rj_wr_en, rj_wr_addr, rj_wr_data, busy, done, sum_err
  );
  modport slave (
    input  start, frame, in_bit, bit_valid,
    output rj_wr_en, rj_wr_addr, rj_wr_data, busy, done, sum_err
  );
`else
  modport master (
    output start, frame, in_bit, bit_valid,
    input  rj_wr_en, rj_wr_addr, rj_wr_data, busy, done
  );
  modport slave (
    input  start, frame, in_bit, bit_valid,
    output rj_wr_en, rj_wr_addr, rj_wr_data, busy, done
  );
`endif
endinterface

// File: rtl/rj_loader.sv
// Deserialises frame-aligned MSB-first rj words and writes them into the 16-entry rj memory.
// Optional rj sum check is compiled in with RJ_LOADER_SUM_CHK_EN.
module rj_loader #(
  parameter int WORD_W = 16,
  parameter int NUM_RJ = 16
`ifdef RJ_LOADER_SUM_CHK_EN
  ,
  parameter int RJ_SUM = 256
`endif
) (
  input  logic        Sclk,
  input  logic        Reset_n,
  rj_loader_if.slave  bus
);

  localparam int ADDR_W = $clog2(NUM_RJ);
  localparam int CNT_W  = $clog2(WORD_W) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RJ - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [WORD_W-1:0]   wr_data_reg, wr_data_next;
  logic                wr_en_reg, wr_en_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                frame_bit;
`ifdef RJ_LOADER_SUM_CHK_EN
  logic [19:0]         sum_reg, sum_next;
  logic                sum_err_reg, sum_err_next;
  logic [19:0]         sum_with_word;
`endif

  assign frame_bit = bus.bit_valid && bus.frame;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      wr_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef RJ_LOADER_SUM_CHK_EN
      sum_reg     <= '0;
      sum_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      addr_reg    <= addr_next;
      wr_data_reg <= wr_data_next;
      wr_en_reg   <= wr_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
`ifdef RJ_LOADER_SUM_CHK_EN
      sum_reg     <= sum_next;
      sum_err_reg <= sum_err_next;
`endif
    end
  end

`ifdef RJ_LOADER_SUM_CHK_EN
  // The word on the write port during WRITE is folded in as the state is left.
  assign sum_with_word = sum_reg + 20'(wr_data_reg);
`endif

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    addr_next    = addr_reg;
    wr_data_next = wr_data_reg;
    wr_en_next   = 1'b0;
    done_next    = done_reg;
`ifdef RJ_LOADER_SUM_CHK_EN
    sum_next     = sum_reg;
    sum_err_next = sum_err_reg;
`endif

    if (bus.start) begin
      // start overrides everything, including a bit arriving in the same cycle
      state_next   = WAIT_FRAME;
      bit_cnt_next = '0;
      addr_next    = '0;
      done_next    = 1'b0;
`ifdef RJ_LOADER_SUM_CHK_EN
      sum_next     = '0;
      sum_err_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end

        WAIT_FRAME: begin
          if (frame_bit) begin
            shift_next   = {{(WORD_W-1){1'b0}}, bus.in_bit};
            bit_cnt_next = CNT_W'(1);
            state_next   = SHIFT;
          end
        end

        SHIFT: begin
          if (frame_bit && (bit_cnt_reg != '0)) begin
            // resync: the partial word is dropped and this bit starts a new one
            shift_next   = {{(WORD_W-1){1'b0}}, bus.in_bit};
            bit_cnt_next = CNT_W'(1);
          end else if (bus.bit_valid) begin
            shift_next   = {shift_reg[WORD_W-2:0], bus.in_bit};
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
              wr_data_next = {shift_reg[WORD_W-2:0], bus.in_bit};
              wr_en_next   = 1'b1;
              bit_cnt_next = '0;
              state_next   = WRITE;
            end
          end
        end

        WRITE: begin
`ifdef RJ_LOADER_SUM_CHK_EN
          sum_next = sum_with_word;
`endif
          if (addr_reg == LAST_ADDR) begin
            state_next = DONE;
            done_next  = 1'b1;
`ifdef RJ_LOADER_SUM_CHK_EN
            sum_err_next = (sum_with_word != 20'(RJ_SUM));
`endif
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
            // a framed bit here is the next word's first bit, so it must not be lost
            if (frame_bit) begin
              shift_next   = {{(WORD_W-1){1'b0}}, bus.in_bit};
              bit_cnt_next = CNT_W'(1);
              state_next   = SHIFT;
            end else begin
              state_next = WAIT_FRAME;
            end
          end
        end

        DONE: begin
          state_next = DONE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next == WAIT_FRAME) || (state_next == SHIFT) || (state_next == WRITE);
  end

  assign bus.rj_wr_en   = wr_en_reg;
  assign bus.rj_wr_addr = addr_reg;
  assign bus.rj_wr_data = wr_data_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
`ifdef RJ_LOADER_SUM_CHK_EN
  assign bus.sum_err    = sum_err_reg;
`endif

endmodule

// File: tb/tb_rj_loader.sv
// Directed bench for rj_loader: drivers push expected writes into a queue, a monitor pops and compares.
// Define RJ_LOADER_SUM_CHK_EN to also exercise the sum check.
module tb_rj_loader;
  logic Sclk = 1'b0;
  logic Reset_n = 1'b1;

  rj_loader_if #(.WORD_W(16), .ADDR_W(4)) bus ();

  rj_loader #(.WORD_W(16), .NUM_RJ(16)) dut (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Sclk = ~Sclk;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  int exp_addr = 0;
  int wr_count = 0;
  int base_count;
  logic prev_wr_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the expected queue.
  always @(negedge Sclk) begin
    logic [19:0] e;
    if (Reset_n) begin
      if (bus.rj_wr_en) begin
        wr_count++;
        $display("write addr=%0d data=%04h", bus.rj_wr_addr, bus.rj_wr_data);
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.rj_wr_addr), 32'(e[19:16]));
          check("wr_data", 32'(bus.rj_wr_data), 32'(e[15:0]));
        end
        check("wr_en_one_cycle", 32'(prev_wr_en), 32'd0);
      end
      prev_wr_en = bus.rj_wr_en;
    end else begin
      prev_wr_en = 1'b0;
    end
  end

  task automatic tick();
    @(negedge Sclk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    bus.frame = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send_bits(input logic [15:0] d, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.bit_valid = 1'b1;
      bus.frame = (i == 0);
      bus.in_bit = d[15-i];
      tick();
      bus.bit_valid = 1'b0;
      bus.frame = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_word(input logic [15:0] d, input int gap, input bit expect_wr);
    if (expect_wr) begin
      exp_q.push_back({4'(exp_addr), d});
      exp_addr++;
    end
    send_bits(d, 16, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(bus.rj_wr_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.rj_wr_addr), 32'd0);
    check({tag, "_data"}, 32'(bus.rj_wr_data), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
`ifdef RJ_LOADER_SUM_CHK_EN
    check({tag, "_sum_err"}, 32'(bus.sum_err), 32'd0);
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.frame = 1'b0;
    bus.in_bit = 1'b0;
    bus.bit_valid = 1'b0;
    #1 Reset_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 16 back-to-back words of 16
    pulse_start();
    check("t1_busy_after_start", 32'(bus.busy), 32'd1);
    for (int w = 0; w < 16; w++) send_word(16'h0010, 0, 1'b1);
    check("t1_last_wr_en", 32'(bus.rj_wr_en), 32'd1);
    check("t1_done_not_yet", 32'(bus.done), 32'd0);
    tick();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_done", 32'(bus.busy), 32'd0);
    check("t1_addr_hold", 32'(bus.rj_wr_addr), 32'd15);
    check("t1_data_hold", 32'(bus.rj_wr_data), 32'h0010);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef RJ_LOADER_SUM_CHK_EN
    check("t1_sum_err", 32'(bus.sum_err), 32'd0);
`endif
    tick();
    check("t1_done_sticky", 32'(bus.done), 32'd1);

    // single word with idle cycles between bits
    pulse_start();
    check("t2_done_cleared", 32'(bus.done), 32'd0);
    send_word(16'h8001, 1, 1'b1);
    tick();
    check("t2_wr_en_low", 32'(bus.rj_wr_en), 32'd0);
    check("t2_data_hold", 32'(bus.rj_wr_data), 32'h8001);
    check("t2_addr", 32'(bus.rj_wr_addr), 32'd1);

    // resync after a 7-bit partial word 3
    pulse_start();
    send_word(16'h0001, 0, 1'b1);
    send_word(16'h0002, 0, 1'b1);
    send_word(16'h0003, 0, 1'b1);
    send_bits(16'hFFFF, 7, 0);
    send_word(16'h00A5, 0, 1'b1);
    tick();
    tick();
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_addr", 32'(bus.rj_wr_addr), 32'd4);

    // restart after 9 words; start collides with a framed bit
    pulse_start();
    for (int w = 0; w < 9; w++) send_word(16'(w * 3 + 1), 0, 1'b1);
    tick();
    check("t4_addr_before_restart", 32'(bus.rj_wr_addr), 32'd9);
    bus.bit_valid = 1'b1;
    bus.frame = 1'b1;
    bus.in_bit = 1'b1;
    pulse_start();
    base_count = wr_count;
    check("t4_addr_restart", 32'(bus.rj_wr_addr), 32'd0);
    check("t4_done_restart", 32'(bus.done), 32'd0);
    for (int w = 0; w < 16; w++) begin
      send_word(16'(16'h0100 + w), 0, 1'b1);
      check("t4_done_low_reload", 32'(bus.done), 32'd0);
    end
    tick();
    tick();
    check("t4_write_count", 32'(wr_count - base_count), 32'd16);
    check("t4_done", 32'(bus.done), 32'd1);

    // asynchronous reset in the middle of word 5
    pulse_start();
    for (int w = 0; w < 5; w++) send_word(16'h0F0F, 0, 1'b1);
    send_bits(16'h1234, 8, 0);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    Reset_n = 1'b1;
    send_word(16'hFFFF, 0, 1'b0);
    tick();
    tick();
    check("t5_busy_idle", 32'(bus.busy), 32'd0);
    check("t5_addr_idle", 32'(bus.rj_wr_addr), 32'd0);

`ifdef RJ_LOADER_SUM_CHK_EN
    // wrong rj total: 16 x 15 = 240
    pulse_start();
    for (int w = 0; w < 16; w++) send_word(16'h000F, 0, 1'b1);
    tick();
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_sum_err", 32'(bus.sum_err), 32'd1);
    pulse_start();
    check("t6_sum_err_cleared", 32'(bus.sum_err), 32'd0);
`endif

    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
